// File: rtl/m1_stage_pkg.sv
// Shared widths, field layout and FSM encoding for the memory-stage-1 slice.
package m1_stage_pkg;

  localparam int ES_TO_M1S_BUS1_WD = 76;
  localparam int M1S_TO_M2S_BUS_WD = 77;
  localparam int M1S_FWD_BUS       = 40;
  localparam int RES_FROM_MEM_BIT  = 70;

  typedef enum logic [1:0] {
    M1_IDLE = 2'd0,
    M1_REQ  = 2'd1,
    M1_DONE = 2'd2
  } m1_state_e;

  // Field order matches es_to_m1s_bus from ex_sub1, MSB first.
  typedef struct packed {
    logic        first;
    logic [3:0]  rf_wen;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_bus_t;

endpackage

// File: rtl/m1_stage.sv
// Memory stage 1: latches the ex_sub1 payload, issues load addresses on the
// SRAM-like port and forwards results to ID.
module m1_stage
  import m1_stage_pkg::*;
#(
  parameter int ES_BUS_WD = ES_TO_M1S_BUS1_WD,
  parameter int M2_BUS_WD = M1S_TO_M2S_BUS_WD,
  parameter int FWD_WD    = M1S_FWD_BUS
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 es_to_m1s_valid,
  input  logic [ES_BUS_WD-1:0] es_to_m1s_bus,
  output logic                 m1s_allowin,
  input  logic                 m2s_allowin,
  output logic                 m1s_to_m2s_valid,
  output logic [M2_BUS_WD-1:0] m1s_to_m2s_bus,
  output logic [FWD_WD-1:0]    m1s_fwd_bus,
  output logic                 data_req,
  output logic [31:0]          data_addr,
  input  logic                 data_addr_ok
);

  es_bus_t   bus_r;
  m1_state_e state, state_nxt;
  logic      m1s_valid;
  logic      cancel;
  logic      m1s_ready_go;
  logic      load_in;

  assign m1s_ready_go     = !bus_r.res_from_mem || (state == M1_DONE);
  assign m1s_allowin      = !m1s_valid || (m1s_ready_go && m2s_allowin);
  assign m1s_to_m2s_valid = m1s_valid && m1s_ready_go && !cancel;
  assign load_in          = es_to_m1s_valid && m1s_allowin && !flush
                            && es_to_m1s_bus[RES_FROM_MEM_BIT];

  assign data_req       = (state == M1_REQ);
  assign data_addr      = bus_r.result;
  assign m1s_to_m2s_bus = {(state == M1_DONE), bus_r};
  assign m1s_fwd_bus    = {m1s_valid && !cancel, bus_r.gr_we, bus_r.res_from_mem,
                           bus_r.dest, bus_r.result};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= M1_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A request in flight is never withdrawn; a flushed load just exits to IDLE once accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      M1_IDLE: if (load_in) state_nxt = M1_REQ;
      M1_REQ:  if (data_addr_ok) state_nxt = (cancel || flush) ? M1_IDLE : M1_DONE;
      M1_DONE: begin
        if (flush)            state_nxt = M1_IDLE;
        else if (m1s_allowin) state_nxt = load_in ? M1_REQ : M1_IDLE;
      end
      default: state_nxt = M1_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m1s_valid <= 1'b0;
      cancel    <= 1'b0;
    end else if (state == M1_REQ) begin
      if (data_addr_ok && (cancel || flush)) begin
        m1s_valid <= 1'b0;
        cancel    <= 1'b0;
      end else if (flush) begin
        cancel <= 1'b1;
      end
    end else if (flush) begin
      m1s_valid <= 1'b0;
      cancel    <= 1'b0;
    end else if (m1s_allowin) begin
      m1s_valid <= es_to_m1s_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_r <= '0;
    end else if (es_to_m1s_valid && m1s_allowin) begin
      bus_r <= es_to_m1s_bus;
    end
  end

endmodule

// File: tb/tb_m1_stage.sv
// Self-checking bench for m1_stage: directed scenarios plus a randomized run
// compared against an instruction-level occupancy model.
module tb_m1_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        es_to_m1s_valid;
  logic [75:0] es_to_m1s_bus;
  logic        m1s_allowin;
  logic        m2s_allowin;
  logic        m1s_to_m2s_valid;
  logic [76:0] m1s_to_m2s_bus;
  logic [39:0] m1s_fwd_bus;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_addr_ok;

  int checks   = 0;
  int failures = 0;

  // Model: is an instruction held, is it a load, was its address accepted, was it flushed.
  bit          m_occ, m_load, m_done, m_kill;
  logic [75:0] m_bus;

  always #5 clk = ~clk;

  m1_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .es_to_m1s_valid  (es_to_m1s_valid),
    .es_to_m1s_bus    (es_to_m1s_bus),
    .m1s_allowin      (m1s_allowin),
    .m2s_allowin      (m2s_allowin),
    .m1s_to_m2s_valid (m1s_to_m2s_valid),
    .m1s_to_m2s_bus   (m1s_to_m2s_bus),
    .m1s_fwd_bus      (m1s_fwd_bus),
    .data_req         (data_req),
    .data_addr        (data_addr),
    .data_addr_ok     (data_addr_ok)
  );

  function automatic logic [75:0] mk_bus(input logic ld, input logic we, input logic [4:0] rd,
                                         input logic [31:0] res, input logic [31:0] pc);
    return {1'b0, 4'hf, ld, we, rd, res, pc};
  endfunction

  function automatic logic e_ready();   return !m_load || m_done; endfunction
  function automatic logic e_allowin(); return !m_occ || (e_ready() && m2s_allowin); endfunction
  function automatic logic e_valid();   return m_occ && e_ready() && !m_kill; endfunction
  function automatic logic e_req();     return m_occ && m_load && !m_done; endfunction
  function automatic logic [39:0] e_fwd();
    return {m_occ && !m_kill, m_bus[69], m_bus[70], m_bus[68:64], m_bus[63:32]};
  endfunction
  function automatic logic [76:0] e_m2bus();
    return {m_occ && m_load && m_done, m_bus};
  endfunction

  task automatic model_clear();
    m_occ = 0; m_load = 0; m_done = 0; m_kill = 0; m_bus = '0;
  endtask

  task automatic set_in(input logic v, input logic [75:0] b, input logic m2a,
                        input logic aok, input logic fl);
    @(negedge clk);
    es_to_m1s_valid = v;
    es_to_m1s_bus   = b;
    m2s_allowin     = m2a;
    data_addr_ok    = aok;
    flush           = fl;
    #1;
  endtask

  // Advance the model by one clock using the currently driven inputs, then take the edge.
  task automatic tick();
    logic al;
    al = e_allowin();
    if (m_occ && m_load && !m_done) begin
      if (data_addr_ok) begin
        if (m_kill || flush) begin m_occ = 0; m_kill = 0; end
        else m_done = 1;
      end else if (flush) begin
        m_kill = 1;
      end
    end else if (flush) begin
      m_occ = 0; m_kill = 0;
    end else if (al) begin
      m_occ = es_to_m1s_valid; m_done = 0;
    end
    if (es_to_m1s_valid && al) begin
      m_bus = es_to_m1s_bus; m_load = es_to_m1s_bus[70];
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_in(0, '0, 1, 0, 0);
    model_clear();
    checks++; if (m1s_allowin !== 1'b1) begin failures++; $display("[TB] FAIL reset_allowin got=%b exp=1", m1s_allowin); end
    checks++; if (m1s_to_m2s_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", m1s_to_m2s_valid); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", data_req); end
    checks++; if (m1s_fwd_bus !== 40'h0) begin failures++; $display("[TB] FAIL reset_fwd got=%h exp=0", m1s_fwd_bus); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    set_in(1, mk_bus(0, 1, 5'd5, 32'h1234, 32'h1c00_0000), 1, 0, 0);
    checks++; if (data_req !== 1'b0) begin failures++; $display("[TB] FAIL alu_req0 got=%b exp=0", data_req); end
    tick();
    set_in(0, '0, 1, 0, 0);
    checks++; if (m1s_to_m2s_valid !== 1'b1) begin failures++; $display("[TB] FAIL alu_valid got=%b exp=1", m1s_to_m2s_valid); end
    checks++; if (m1s_fwd_bus !== {1'b1, 1'b1, 1'b0, 5'd5, 32'h1234}) begin failures++; $display("[TB] FAIL alu_fwd got=%h exp=%h", m1s_fwd_bus, {1'b1, 1'b1, 1'b0, 5'd5, 32'h1234}); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("[TB] FAIL alu_req1 got=%b exp=0", data_req); end
    tick();
  endtask

  task automatic test_load();
    set_in(1, mk_bus(1, 1, 5'd7, 32'h8000_0010, 32'h1c00_0004), 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(0, '0, 1, (i == 2), 0);
      checks++; if (data_req !== 1'b1) begin failures++; $display("[TB] FAIL load_req%0d got=%b exp=1", i, data_req); end
      checks++; if (data_addr !== 32'h8000_0010) begin failures++; $display("[TB] FAIL load_addr%0d got=%h exp=80000010", i, data_addr); end
      checks++; if (m1s_allowin !== 1'b0) begin failures++; $display("[TB] FAIL load_allowin%0d got=%b exp=0", i, m1s_allowin); end
      tick();
    end
    set_in(0, '0, 1, 0, 0);
    checks++; if (m1s_to_m2s_valid !== 1'b1) begin failures++; $display("[TB] FAIL load_valid got=%b exp=1", m1s_to_m2s_valid); end
    checks++; if (m1s_to_m2s_bus[76] !== 1'b1) begin failures++; $display("[TB] FAIL load_req_sent got=%b exp=1", m1s_to_m2s_bus[76]); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("[TB] FAIL load_req_done got=%b exp=0", data_req); end
    tick();
  endtask

  task automatic test_stall();
    logic [75:0] a, b;
    a = mk_bus(0, 1, 5'd9, 32'hdead_beef, 32'h1c00_0010);
    b = mk_bus(0, 1, 5'd3, 32'h0bad_f00d, 32'h1c00_0014);
    set_in(1, a, 1, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(1, b, 0, 0, 0);
      checks++; if (m1s_allowin !== 1'b0) begin failures++; $display("[TB] FAIL stall_allowin%0d got=%b exp=0", i, m1s_allowin); end
      checks++; if (m1s_to_m2s_bus !== {1'b0, a}) begin failures++; $display("[TB] FAIL stall_bus%0d got=%h exp=%h", i, m1s_to_m2s_bus, {1'b0, a}); end
      checks++; if (m1s_to_m2s_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid%0d got=%b exp=1", i, m1s_to_m2s_valid); end
      tick();
    end
    set_in(0, '0, 1, 0, 0);
    checks++; if (m1s_to_m2s_bus[75:0] !== a) begin failures++; $display("[TB] FAIL stall_release got=%h exp=%h", m1s_to_m2s_bus[75:0], a); end
    tick();
  endtask

  task automatic test_flush_req();
    set_in(1, mk_bus(1, 1, 5'd4, 32'h8000_0100, 32'h1c00_0020), 1, 0, 0);
    tick();
    set_in(0, '0, 1, 0, 1);
    checks++; if (data_req !== 1'b1) begin failures++; $display("[TB] FAIL flush_req0 got=%b exp=1", data_req); end
    tick();
    set_in(0, '0, 1, 0, 0);
    checks++; if (data_req !== 1'b1) begin failures++; $display("[TB] FAIL flush_req1 got=%b exp=1", data_req); end
    checks++; if (m1s_to_m2s_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid1 got=%b exp=0", m1s_to_m2s_valid); end
    checks++; if (m1s_allowin !== 1'b0) begin failures++; $display("[TB] FAIL flush_allowin1 got=%b exp=0", m1s_allowin); end
    tick();
    set_in(0, '0, 1, 1, 0);
    checks++; if (data_req !== 1'b1) begin failures++; $display("[TB] FAIL flush_req2 got=%b exp=1", data_req); end
    checks++; if (m1s_fwd_bus[39] !== 1'b0) begin failures++; $display("[TB] FAIL flush_fwdv got=%b exp=0", m1s_fwd_bus[39]); end
    tick();
    set_in(0, '0, 1, 0, 0);
    checks++; if (m1s_allowin !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty got=%b exp=1", m1s_allowin); end
    checks++; if (m1s_to_m2s_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid3 got=%b exp=0", m1s_to_m2s_valid); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("[TB] FAIL flush_req3 got=%b exp=0", data_req); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [75:0] l1, l2;
    l1 = mk_bus(1, 1, 5'd1, 32'h8000_0200, 32'h1c00_0030);
    l2 = mk_bus(1, 1, 5'd2, 32'h8000_0204, 32'h1c00_0034);
    set_in(1, l1, 1, 0, 0);
    tick();
    set_in(1, l2, 1, 1, 0);
    checks++; if (data_addr !== 32'h8000_0200) begin failures++; $display("[TB] FAIL b2b_addr1 got=%h exp=80000200", data_addr); end
    checks++; if (m1s_allowin !== 1'b0) begin failures++; $display("[TB] FAIL b2b_allowin1 got=%b exp=0", m1s_allowin); end
    tick();
    set_in(1, l2, 1, 0, 0);
    checks++; if (m1s_to_m2s_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid1 got=%b exp=1", m1s_to_m2s_valid); end
    checks++; if (data_req !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap got=%b exp=0", data_req); end
    tick();
    set_in(0, '0, 1, 1, 0);
    checks++; if (data_req !== 1'b1) begin failures++; $display("[TB] FAIL b2b_req2 got=%b exp=1", data_req); end
    checks++; if (data_addr !== 32'h8000_0204) begin failures++; $display("[TB] FAIL b2b_addr2 got=%h exp=80000204", data_addr); end
    tick();
    set_in(0, '0, 1, 0, 0);
    checks++; if (m1s_to_m2s_bus !== {1'b1, l2}) begin failures++; $display("[TB] FAIL b2b_bus2 got=%h exp=%h", m1s_to_m2s_bus, {1'b1, l2}); end
    tick();
  endtask

  task automatic test_async_reset();
    set_in(1, mk_bus(1, 1, 5'd6, 32'h8000_0300, 32'h1c00_0040), 1, 0, 0);
    tick();
    set_in(0, '0, 1, 0, 0);
    checks++; if (data_req !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre got=%b exp=1", data_req); end
    #1 resetn = 1'b0;
    #1;
    model_clear();
    checks++; if (data_req !== 1'b0) begin failures++; $display("[TB] FAIL areset_req got=%b exp=0", data_req); end
    checks++; if (m1s_allowin !== 1'b1) begin failures++; $display("[TB] FAIL areset_allowin got=%b exp=1", m1s_allowin); end
    checks++; if (m1s_fwd_bus[39] !== 1'b0) begin failures++; $display("[TB] FAIL areset_fwdv got=%b exp=0", m1s_fwd_bus[39]); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_random();
    logic [75:0] b;
    for (int i = 0; i < 400; i++) begin
      b = mk_bus(($urandom_range(0, 2) == 0), $urandom_range(0, 1), 5'($urandom),
                 $urandom, $urandom);
      set_in($urandom_range(0, 1), b, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      checks++; if (m1s_allowin !== e_allowin()) begin failures++; $display("[TB] FAIL rnd_allowin c%0d got=%b exp=%b", i, m1s_allowin, e_allowin()); end
      checks++; if (m1s_to_m2s_valid !== e_valid()) begin failures++; $display("[TB] FAIL rnd_valid c%0d got=%b exp=%b", i, m1s_to_m2s_valid, e_valid()); end
      checks++; if (data_req !== e_req()) begin failures++; $display("[TB] FAIL rnd_req c%0d got=%b exp=%b", i, data_req, e_req()); end
      checks++; if (m1s_fwd_bus !== e_fwd()) begin failures++; $display("[TB] FAIL rnd_fwd c%0d got=%h exp=%h", i, m1s_fwd_bus, e_fwd()); end
      checks++; if (m1s_to_m2s_bus !== e_m2bus()) begin failures++; $display("[TB] FAIL rnd_bus c%0d got=%h exp=%h", i, m1s_to_m2s_bus, e_m2bus()); end
      if (e_req()) begin
        checks++; if (data_addr !== m_bus[63:32]) begin failures++; $display("[TB] FAIL rnd_addr c%0d got=%h exp=%h", i, data_addr, m_bus[63:32]); end
      end
      tick();
    end
  endtask

  initial begin
    resetn = 1'b0; flush = 0; es_to_m1s_valid = 0; es_to_m1s_bus = '0;
    m2s_allowin = 1; data_addr_ok = 0;
    model_clear();
    test_reset();
    test_alu();
    test_load();
    test_stall();
    test_flush_req();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
